// File: rtl/picorv32_console_uart.sv
// Console peripheral for the picorv32 native memory bus.
// Byte stores fill a TX FIFO that an 8N1 serializer drains; a status word exposes FIFO/line state.
module picorv32_console_uart #(
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter int unsigned CLK_DIV      = 16,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic        tx_busy
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    tx_state_t       state, state_next;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level;
    logic [7:0]      shift_reg;
    logic [2:0]      bit_cnt;
    logic [BW-1:0]   baud_cnt;
    logic            fifo_empty, fifo_full;
    logic            hit_data, hit_stat, is_write, accept, push, pop, baud_done;
    logic [31:0]     status_word;
    logic            unused_bits;

    assign unused_bits = ^mem_wdata[31:8];

    assign hit_data   = mem_valid && (mem_addr == CONSOLE_ADDR);
    assign hit_stat   = mem_valid && (mem_addr == CONSOLE_ADDR + 32'd4);
    assign is_write   = |mem_wstrb;
    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LW'(FIFO_DEPTH));
    // A full FIFO holds off only data writes; reads and status accesses still complete.
    assign accept     = !mem_ready && (hit_stat || (hit_data && (!is_write || !fifo_full)));
    assign push       = accept && hit_data && is_write;
    assign pop        = (state == IDLE) && !fifo_empty;
    assign baud_done  = (baud_cnt == BW'(CLK_DIV - 1));

    always_comb begin
        status_word       = '0;
        status_word[0]    = fifo_empty;
        status_word[1]    = fifo_full;
        status_word[2]    = tx_busy;
        status_word[15:8] = 8'(level);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
        end else begin
            mem_ready <= accept;
            mem_rdata <= (accept && hit_stat && !is_write) ? status_word : '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= mem_wdata[7:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            baud_cnt  <= '0;
        end else if (state == IDLE) begin
            if (pop) begin
                shift_reg <= fifo_mem[rd_ptr];
                bit_cnt   <= '0;
                baud_cnt  <= '0;
            end
        end else begin
            baud_cnt <= baud_done ? '0 : baud_cnt + BW'(1);
            if (state == DATA && baud_done) begin
                shift_reg <= shift_reg >> 1;
                bit_cnt   <= bit_cnt + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pop) state_next = START;
            START:   if (baud_done) state_next = DATA;
            DATA:    if (baud_done && bit_cnt == 3'd7) state_next = STOP;
            STOP:    if (baud_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        uart_tx = 1'b1;
        tx_busy = (state != IDLE);
        case (state)
            START:   uart_tx = 1'b0;
            DATA:    uart_tx = shift_reg[0];
            default: uart_tx = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_picorv32_console_uart.sv
// Directed bench for picorv32_console_uart: bus decode table, framing, FIFO stall and reset abort.
module tb_picorv32_console_uart;
    localparam int unsigned D     = 4;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] ADDR  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        uart_tx;
    logic        tx_busy;

    picorv32_console_uart #(
        .CONSOLE_ADDR(ADDR),
        .CLK_DIV(D),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .mem_valid(mem_valid),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .uart_tx(uart_tx),
        .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          falls = 0;
    int          framing_err = 0;
    int          fall_cyc[$];
    logic [7:0]  rx_q[$];
    logic        rx_prev = 1'b1;
    logic [7:0]  rx_byte = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: samples each bit in its middle, counting cycles from the first low sample.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rx_prev && !uart_tx) begin
                falls++;
                fall_cyc.push_back(cyc);
                for (int j = 1; j <= int'(10*D - 2); j++) begin
                    @(posedge clk); #1;
                    if (j % D == D/2 && j / D >= 1 && j / D <= 8)
                        rx_byte[j/D - 1] = uart_tx;
                end
                if (uart_tx) rx_q.push_back(rx_byte);
                else framing_err++;
            end
            rx_prev = uart_tx;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                       input int budget, output bit acked, output logic [31:0] rdata, output int waited);
        @(posedge clk); #1;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = strb;
        acked = 1'b0;
        rdata = '0;
        waited = 0;
        while (!acked && waited < budget) begin
            @(posedge clk); #1;
            waited++;
            if (mem_ready) begin
                acked = 1'b1;
                rdata = mem_rdata;
            end
        end
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic [3:0] strb, input string name);
        bit acked;
        logic [31:0] rdata;
        int waited;
        bus(ADDR, {24'h0, b}, strb, 64, acked, rdata, waited);
        check({name, "_ack"}, 32'(acked), 32'd1);
        check({name, "_latency"}, waited, 32'd1);
    endtask

    task automatic rd_stat(input logic [31:0] exp, input string name);
        bit acked;
        logic [31:0] rdata;
        int waited;
        bus(ADDR + 32'd4, 32'h0, 4'h0, 64, acked, rdata, waited);
        check({name, "_ack"}, 32'(acked), 32'd1);
        check({name, "_rdata"}, rdata, exp);
    endtask

    int idle_cyc;
    task automatic wait_idle(input int budget, input string name);
        int low = 0;
        int n = 0;
        while (low < 2 && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (tx_busy) low = 0;
            else begin
                if (low == 0) idle_cyc = cyc;
                low++;
            end
        end
        check({name, "_idle"}, 32'(low >= 2), 32'd1);
    endtask

    function automatic logic [31:0] rx_at(input int k);
        return (k < rx_q.size()) ? {24'h0, rx_q[k]} : 32'hDEAD_BEEF;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          exp_ack;
        logic [31:0] exp_rdata;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vt[8];
        bit          acked;
        logic [31:0] rdata;
        logic [9:0]  frame;
        int          waited, n0, f;

        vt[0] = '{ADDR + 32'd4, 32'h0,        4'h0, 1'b1, 32'h1};
        vt[1] = '{ADDR + 32'd8, 32'h0,        4'h0, 1'b0, 32'h0};
        vt[2] = '{ADDR + 32'd8, 32'h77,       4'hF, 1'b0, 32'h0};
        vt[3] = '{32'h0,        32'h0,        4'h0, 1'b0, 32'h0};
        vt[4] = '{32'h0,        32'h77,       4'h1, 1'b0, 32'h0};
        vt[5] = '{ADDR,         32'h0,        4'h0, 1'b1, 32'h0};
        vt[6] = '{ADDR + 32'd4, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0};
        vt[7] = '{ADDR + 32'd4, 32'h0,        4'h0, 1'b1, 32'h1};

        repeat (3) @(posedge clk);
        #1;
        check("reset_uart_tx", 32'(uart_tx), 32'd1);
        check("reset_mem_ready", 32'(mem_ready), 32'd0);
        check("reset_mem_rdata", mem_rdata, 32'd0);
        check("reset_tx_busy", 32'(tx_busy), 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            bus(vt[i].addr, vt[i].wdata, vt[i].strb, 6, acked, rdata, waited);
            check($sformatf("vec%0d_ack", i), 32'(acked), 32'(vt[i].exp_ack));
            if (vt[i].exp_ack) check($sformatf("vec%0d_rdata", i), rdata, vt[i].exp_rdata);
            check($sformatf("vec%0d_line", i), {31'h0, uart_tx}, 32'd1);
        end
        check("decode_no_frames", falls, 32'd0);

        // Single 0x55 frame sampled cycle by cycle: start, LSB-first data, stop.
        wr_byte(8'h55, 4'hF, "w55");
        frame = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < int'(10*D); k++) begin
            @(posedge clk); #1;
            if (k == 0) check("w55_ready_drop", 32'(mem_ready), 32'd0);
            check($sformatf("w55_line_c%0d", k), {30'h0, tx_busy, uart_tx}, {30'h0, 1'b1, frame[k/D]});
        end
        @(posedge clk); #1;
        check("w55_after_frame", {30'h0, tx_busy, uart_tx}, 32'h1);
        check("w55_rx_count", rx_q.size(), 32'd1);
        check("w55_rx_byte", rx_at(0), 32'h55);
        rx_q.delete();

        // Three writes while the first frame is on the line: two remain queued.
        wr_byte(8'h10, 4'h1, "s1");
        wr_byte(8'h20, 4'h3, "s2");
        wr_byte(8'h30, 4'hF, "s3");
        rd_stat(32'h0000_0204, "stat_busy");
        wait_idle(1000, "stat_drain");
        check("stat_rx_count", rx_q.size(), 32'd3);
        for (int k = 0; k < 3; k++) check($sformatf("stat_rx%0d", k), rx_at(k), 32'h10 * (k + 1));
        rx_q.delete();

        // Back-to-back frames: one idle-high cycle between stop and the next start.
        n0 = fall_cyc.size();
        wr_byte(8'hA5, 4'h1, "b2b1");
        wr_byte(8'h3C, 4'h1, "b2b2");
        wait_idle(1000, "b2b_drain");
        check("b2b_fall_count", fall_cyc.size() - n0, 32'd2);
        check("b2b_start_spacing", fall_cyc[n0 + 1] - fall_cyc[n0], 32'(10*D + 1));
        check("b2b_total", idle_cyc - fall_cyc[n0], 32'(20*D + 1));
        check("b2b_rx0", rx_at(0), 32'hA5);
        check("b2b_rx1", rx_at(1), 32'h3C);
        rx_q.delete();

        // 17 writes fill the FIFO (byte 0 already moved into the shifter); the next one stalls.
        for (int k = 0; k < 17; k++) wr_byte(8'(8'h41 + k), 4'h1, $sformatf("fill%0d", k));
        rd_stat(32'h0000_1006, "stat_full");
        bus(ADDR, 32'h52, 4'h1, 200, acked, rdata, waited);
        check("stall_ack", 32'(acked), 32'd1);
        check("stall_cycles", waited, 32'd8);
        wait_idle(2000, "fill_drain");
        check("fill_rx_count", rx_q.size(), 32'd18);
        for (int k = 0; k < 18; k++) check($sformatf("fill_rx%0d", k), rx_at(k), 32'h41 + k);
        rd_stat(32'h0000_0001, "stat_drained");
        check("framing_errors", framing_err, 32'd0);
        rx_q.delete();

        // Reset in the middle of data bit 3 with bytes still queued.
        for (int k = 0; k < 5; k++) wr_byte(8'(8'h81 + k), 4'h1, $sformatf("rst_w%0d", k));
        @(posedge clk); #2;
        f = fall_cyc[$];
        waited = 0;
        while (cyc < f + 4*D + 1 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check("rst_reach_bit3", 32'(cyc == f + 4*D + 1), 32'd1);
        check("rst_pre_busy", 32'(tx_busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("rst_uart_tx", 32'(uart_tx), 32'd1);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_mem_ready", 32'(mem_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        n0 = falls;
        rd_stat(32'h0000_0001, "rst_stat");
        repeat (100) @(posedge clk);
        #1;
        check("rst_no_frames", falls - n0, 32'd0);
        check("rst_line_idle", {30'h0, tx_busy, uart_tx}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
